// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage in front of the memory controller.
//
// Holds the architectural PC and offers it to the instruction cache for a
// same-cycle hit check. A hit goes straight into a one-entry output slot.
// A miss starts a word read on the memory controller, and the returned word
// goes into the slot. Decode drains the slot under stall_id backpressure.
// A branch redirect flushes the slot and the fetch stream.
//
// Optional build macro: IF_STATIC_PREDICT_EN. When it is defined, the
// instruction entering the slot is predecoded. JAL and backward conditional
// branches are predicted taken. When it is not defined, the next PC is
// always pc+4 and if_pred_taken is tied low.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   rdy             global enable; when low, all state is frozen
//   pc_to_cache     current PC to the I-cache (combinational from pc_q)
//   icache_hit/val  same-cycle cache hit flag and instruction
//   mem_req/addr    word-read request to the memory controller
//   mem_status      00 IDLE, 01 WORKING, 10 DONE (one-cycle pulse)
//   mem_data        returned word, valid while mem_status == 10
//   redirect/_pc    taken branch/jump and its target
//   stall_id        decode cannot accept the slot this cycle
//   if_valid/pc/inst/pred_taken   output slot to decode
// ---------------------------------------------------------------------------
module if_fetch #(
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   output logic [ADDR_W-1:0] pc_to_cache,
   input  logic              icache_hit,
   input  logic [31:0]       icache_val,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [1:0]        mem_status,
   input  logic [31:0]       mem_data,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              stall_id,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [31:0]       if_inst,
   output logic              if_pred_taken
);

   typedef enum logic [1:0] {S_FETCH = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              vld_q, vld_d;
   logic [ADDR_W-1:0] slot_pc_q, slot_pc_d;
   logic [31:0]       slot_inst_q, slot_inst_d;
   logic [31:0]       buf_q, buf_d;
   logic              buf_vld_q, buf_vld_d;
   logic              discard_q, discard_d;
   logic              pred_q, pred_d;

   logic              slot_free, done, working, load;
   logic [31:0]       in_inst;
   logic [ADDR_W-1:0] next_pc;
   logic              in_taken;

`ifdef IF_STATIC_PREDICT_EN
   // Static prediction: JAL is always taken. A conditional branch is taken
   // only when its offset is negative, which usually means a loop back-edge.
   function automatic logic [ADDR_W-1:0] predict_next_pc(
      input  logic [ADDR_W-1:0] pc,
      input  logic [31:0]       inst,
      output logic              taken
   );
      logic signed [ADDR_W-1:0] j_imm;
      logic signed [ADDR_W-1:0] b_imm;
      logic        [ADDR_W-1:0] res;
      j_imm = {{(ADDR_W-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      b_imm = {{(ADDR_W-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      taken = 1'b0;
      res   = pc + ADDR_W'(4);
      if (inst[6:0] == 7'b1101111) begin
         taken = 1'b1;
         res   = pc + j_imm;
      end else if (inst[6:0] == 7'b1100011 && inst[31]) begin
         taken = 1'b1;
         res   = pc + b_imm;
      end
      return res;
   endfunction
`endif

   assign slot_free = !vld_q || !stall_id;
   assign done      = (mem_status == 2'b10);
   assign working   = (mem_status == 2'b01);

   // The instruction that could enter the slot this cycle depends on where it
   // comes from: the cache in FETCH, the controller in WAIT, the buffer in HOLD.
   always_comb begin
      in_inst = icache_val;
      case (state_q)
         S_WAIT:  in_inst = mem_data;
         S_HOLD:  in_inst = buf_q;
         default: in_inst = icache_val;
      endcase
   end

`ifdef IF_STATIC_PREDICT_EN
   always_comb begin
      in_taken = 1'b0;
      next_pc  = predict_next_pc(pc_q, in_inst, in_taken);
   end
`else
   assign in_taken = 1'b0;
   assign next_pc  = pc_q + ADDR_W'(4);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst)      state_q <= S_FETCH;
      else if (rdy) state_q <= state_d;
   end

   // Next-state logic. A redirect outranks everything else, but an
   // outstanding memory read is always allowed to finish.
   always_comb begin
      state_d = state_q;
      if (redirect) begin
         state_d = (state_q == S_WAIT && !done) ? S_WAIT : S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: if (!icache_hit) state_d = S_WAIT;
            S_WAIT:  if (done) state_d = (discard_q || slot_free) ? S_FETCH : S_HOLD;
            S_HOLD:  if (slot_free) state_d = S_FETCH;
            default: state_d = S_FETCH;
         endcase
      end
   end

   // Datapath / output next values
   always_comb begin
      pc_d        = pc_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      vld_d       = vld_q && stall_id;   // slot drains when decode takes it
      slot_pc_d   = slot_pc_q;
      slot_inst_d = slot_inst_q;
      buf_d       = buf_q;
      buf_vld_d   = buf_vld_q;
      discard_d   = discard_q;
      pred_d      = pred_q;
      load        = 1'b0;

      // The request handshake runs on its own, even under a redirect.
      if (state_q == S_WAIT) begin
         if (working) mem_req_d = 1'b0;
         if (done) begin
            mem_req_d  = 1'b0;
            mem_addr_d = '0;
         end
      end

      if (redirect) begin
         vld_d     = 1'b0;
         buf_vld_d = 1'b0;
         pc_d      = redirect_pc;
         if (state_q == S_WAIT) discard_d = !done;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (icache_hit) begin
                  if (slot_free) load = 1'b1;
               end else begin
                  mem_req_d  = 1'b1;
                  mem_addr_d = pc_q;
               end
            end
            S_WAIT: begin
               if (done) begin
                  if (discard_q)      discard_d = 1'b0;
                  else if (slot_free) load = 1'b1;
                  else begin
                     buf_d     = mem_data;
                     buf_vld_d = 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (slot_free) begin
                  load      = 1'b1;
                  buf_vld_d = 1'b0;
               end
            end
            default: ;
         endcase
      end

      if (load) begin
         vld_d       = 1'b1;
         slot_pc_d   = pc_q;
         slot_inst_d = in_inst;
         pc_d        = next_pc;
         pred_d      = in_taken;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         vld_q       <= 1'b0;
         slot_pc_q   <= '0;
         slot_inst_q <= '0;
         buf_vld_q   <= 1'b0;
         discard_q   <= 1'b0;
         pred_q      <= 1'b0;
      end else if (rdy) begin
         pc_q        <= pc_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         vld_q       <= vld_d;
         slot_pc_q   <= slot_pc_d;
         slot_inst_q <= slot_inst_d;
         buf_vld_q   <= buf_vld_d;
         discard_q   <= discard_d;
         pred_q      <= pred_d;
      end
   end

   // The hold buffer is plain data; buf_vld_q/state qualify it.
   always_ff @(posedge clk) begin
      if (rdy) buf_q <= buf_d;
   end

   assign pc_to_cache = pc_q;
   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign if_valid    = vld_q;
   assign if_pc       = slot_pc_q;
   assign if_inst     = slot_inst_q;
`ifdef IF_STATIC_PREDICT_EN
   assign if_pred_taken = pred_q;
`else
   assign if_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic [31:0] pc_to_cache;
   logic        icache_hit;
   logic [31:0] icache_val;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [1:0]  mem_status;
   logic [31:0] mem_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall_id;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_pred_taken;

   int checks = 0;
   int errors = 0;

   if_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .pc_to_cache(pc_to_cache),
      .icache_hit(icache_hit), .icache_val(icache_val),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_status(mem_status), .mem_data(mem_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .stall_id(stall_id),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
      .if_pred_taken(if_pred_taken)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory contents seen by both cache and controller: unique per word,
   // always an ALU-immediate opcode, so the fetch stream is purely sequential.
   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[26:2] ^ 25'h0ABCDEF, 7'h13};
   endfunction

   // Reference-model state for the random phase
   logic [31:0] exp_pc;
   int          delivered;
   int          m_phase;     // 0 idle, 1 request in flight
   int          m_left;      // WORKING cycles still to present before DONE
   logic [31:0] m_addr;
   bit          drop_pend, done_pend;
   logic [31:0] p0, p1;

   initial begin
      rst = 1'b1; rdy = 1'b1; icache_hit = 1'b0; icache_val = '0;
      mem_status = 2'b00; mem_data = '0; redirect = 1'b0; redirect_pc = '0;
      stall_id = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      chk("rst_valid", if_valid, 0);
      chk("rst_pc", if_pc, 0);
      chk("rst_inst", if_inst, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_pc_cache", pc_to_cache, 32'h0);
      chk("rst_pred", if_pred_taken, 0);

      // Back-to-back hits: one instruction per cycle, no memory traffic
      icache_hit = 1'b1; icache_val = 32'h00000013;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("hit_valid", if_valid, 1);
         chk("hit_pc", if_pc, 32'(4 * i));
         chk("hit_noreq", mem_req, 0);
      end

      // Miss at 0x10
      icache_hit = 1'b0;
      tick();
      chk("miss_req", mem_req, 1);
      chk("miss_addr", mem_addr, 32'h10);
      chk("miss_slot_drained", if_valid, 0);
      tick();
      chk("miss_req_held", mem_req, 1);
      mem_status = 2'b01;
      tick();
      chk("miss_req_drop", mem_req, 0);
      chk("miss_addr_stable", mem_addr, 32'h10);
      mem_status = 2'b10; mem_data = 32'hDEADBEEF;
      tick();
      mem_status = 2'b00;
      chk("miss_valid", if_valid, 1);
      chk("miss_pc", if_pc, 32'h10);
      chk("miss_inst", if_inst, 32'hDEADBEEF);
      chk("miss_next_pc", pc_to_cache, 32'h14);
      chk("miss_addr_clr", mem_addr, 0);

      // Miss while decode stalls: data parks in the hold buffer
      stall_id = 1'b1;
      tick();
      chk("hold_req", mem_req, 1);
      chk("hold_addr", mem_addr, 32'h14);
      mem_status = 2'b01;
      tick();
      mem_status = 2'b10; mem_data = 32'h12345678;
      tick();
      mem_status = 2'b00;
      chk("hold_slot_kept", if_pc, 32'h10);
      tick();
      chk("hold_slot_kept2", if_inst, 32'hDEADBEEF);
      stall_id = 1'b0;
      tick();
      chk("hold_rel_pc", if_pc, 32'h14);
      chk("hold_rel_inst", if_inst, 32'h12345678);
      chk("hold_rel_next", pc_to_cache, 32'h18);

      // Redirect while slot is valid and stalled
      stall_id = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
      tick();
      redirect = 1'b0; stall_id = 1'b0;
      chk("redir_flush", if_valid, 0);
      chk("redir_pc", pc_to_cache, 32'h300);
      chk("redir_noreq", mem_req, 0);

      // Redirect during an outstanding miss: returned word is discarded
      tick();
      chk("disc_req", mem_addr, 32'h300);
      mem_status = 2'b01;
      tick();
      redirect = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      chk("disc_pc", pc_to_cache, 32'h200);
      chk("disc_noreq", mem_req, 0);
      tick();
      mem_status = 2'b10; mem_data = 32'hBAD0BAD0;
      tick();
      mem_status = 2'b00;
      chk("disc_dropped", if_valid, 0);
      tick();
      chk("disc_refetch_req", mem_req, 1);
      chk("disc_refetch_addr", mem_addr, 32'h200);
      chk("disc_still_empty", if_valid, 0);
      mem_status = 2'b01;
      tick();
      mem_status = 2'b10; mem_data = 32'hCAFEF00D;
      tick();
      mem_status = 2'b00;
      chk("disc_new_valid", if_valid, 1);
      chk("disc_new_pc", if_pc, 32'h200);
      chk("disc_new_inst", if_inst, 32'hCAFEF00D);

      // rdy low freezes everything
      rdy = 1'b0; icache_hit = 1'b1; icache_val = 32'h13;
      tick();
      chk("frz_pc", if_pc, 32'h200);
      chk("frz_next", pc_to_cache, 32'h204);
      rdy = 1'b1;

      // Static prediction: JAL +0x40 at pc 0x8, then a backward branch (-8)
      redirect = 1'b1; redirect_pc = 32'h8;
      tick();
      redirect = 1'b0;
      icache_val = 32'h0400006F;
      tick();
      chk("jal_pc", if_pc, 32'h8);
`ifdef IF_STATIC_PREDICT_EN
      chk("jal_pred", if_pred_taken, 1);
      p0 = 32'h48;
`else
      chk("jal_pred", if_pred_taken, 0);
      p0 = 32'hC;
`endif
      icache_val = 32'hFE000CE3;
      tick();
      chk("jal_target", if_pc, p0);
`ifdef IF_STATIC_PREDICT_EN
      chk("br_pred", if_pred_taken, 1);
      p1 = p0 - 32'd8;
`else
      chk("br_pred", if_pred_taken, 0);
      p1 = p0 + 32'd4;
`endif
      icache_val = 32'h13;
      tick();
      chk("br_target", if_pc, p1);
      chk("br_after_pred", if_pred_taken, 0);

      // Random phase against a stream-level reference model
      icache_hit = 1'b0; redirect = 1'b1; redirect_pc = 32'h1000;
      tick();
      redirect = 1'b0;
      exp_pc = 32'h1000; delivered = 0; m_phase = 0; m_left = 0; m_addr = '0;
      drop_pend = 1'b0; done_pend = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (drop_pend) chk("rnd_req_drop", mem_req, 0);
         if (done_pend) chk("rnd_addr_clr", mem_addr, 0);
         drop_pend = 1'b0; done_pend = 1'b0;
         if (m_phase == 1 && mem_req) chk("rnd_addr_stable", mem_addr, m_addr);

         rdy         = ($urandom_range(0, 7) != 0);
         stall_id    = ($urandom_range(0, 2) == 0);
         redirect    = ($urandom_range(0, 15) == 0);
         redirect_pc = $urandom & 32'h0000_3FFC;
         icache_hit  = $urandom_range(0, 1) == 1;
         icache_val  = inst_of(pc_to_cache);

         if (m_phase == 0 && mem_req) begin
            m_phase = 1; m_addr = mem_addr; m_left = $urandom_range(1, 4);
         end
         if (m_phase == 1 && m_left == 0) begin
            mem_status = 2'b10; mem_data = inst_of(m_addr);
         end else begin
            mem_status = (m_phase == 1) ? 2'b01 : 2'b00;
            mem_data   = $urandom;
         end

         if (rdy) begin
            if (!redirect && if_valid && !stall_id) begin
               chk("rnd_pc", if_pc, exp_pc);
               chk("rnd_inst", if_inst, inst_of(exp_pc));
               exp_pc = exp_pc + 32'd4;
               delivered++;
            end
            if (redirect) exp_pc = redirect_pc;
            if (mem_status == 2'b01) begin
               m_left--; drop_pend = 1'b1;
            end else if (mem_status == 2'b10) begin
               m_phase = 0; done_pend = 1'b1;
            end
         end
         tick();
      end
      chk("rnd_progress", (delivered > 200), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
